// File: rtl/alu_pkg.sv
// alu_pkg: ALU op-code constants shared with ALU control, plus the default datapath width
package alu_pkg;
  localparam int DATA_W_DEF = 64;
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: EX-stage ALU bus; master drives valid_in/alu_control/alu_in_0/alu_in_1, slave returns alu_out/zero_flag/valid_out/busy
interface alu_exec_unit_if
  import alu_pkg::*;
#(parameter int DATA_W = DATA_W_DEF);
  logic valid_in;
  logic [3:0] alu_control;
  logic [DATA_W-1:0] alu_in_0, alu_in_1, alu_out;
  logic zero_flag, valid_out, busy;
  modport master(output valid_in, alu_control, alu_in_0, alu_in_1, input alu_out, zero_flag, valid_out, busy);
  modport slave(input valid_in, alu_control, alu_in_0, alu_in_1, output alu_out, zero_flag, valid_out, busy);
endinterface

// File: rtl/alu_exec_unit_seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one iteration per step; ports clk/rst, start+a/b load, step advances, done marks the last iteration with product = final low DATA_W bits
module seq_multiplier #(parameter int DATA_W = 64) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W);
  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0] cnt;
  assign product = mplier[0] ? acc + mcand : acc;
  assign done = step && cnt == CNT_W'(DATA_W - 1);
  always_ff @(posedge clk)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered EX-stage ALU; clk/rst plus slave bus (op/operands in, alu_out/zero_flag/valid_out/busy out), MUL runs DATA_W cycles on seq_multiplier
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input logic clk,
  input logic rst,
  alu_exec_unit_if.slave bus
);
  typedef enum logic {IDLE, MUL} state_e;
  state_e state, state_nx;
  logic start, step, mul_done, load;
  logic [DATA_W-1:0] a, b, sc_res, product, res;
  logic [3:0] op;
  assign a = bus.alu_in_0;
  assign b = bus.alu_in_1;
  assign op = bus.alu_control;
  always_comb
    sc_res = op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_ADD ? a + b :
             op == OP_SUB ? a - b :
             op == OP_SLL ? a << b[SHAMT_W-1:0] :
             op == OP_SRL ? a >> b[SHAMT_W-1:0] :
             op == OP_SLT ? {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)} : '0;
  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(start),
    .step(step),
    .a(a),
    .b(b),
    .done(mul_done),
    .product(product)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.valid_in && op == OP_MUL ? MUL : IDLE) : (mul_done ? IDLE : MUL);
  always_comb begin
    bus.busy = state == MUL;
    start = state == IDLE && bus.valid_in && op == OP_MUL;
    step = state == MUL;
    load = (state == IDLE && bus.valid_in && op != OP_MUL) || mul_done;
    res = mul_done ? product : sc_res;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.alu_out <= '0;
      bus.zero_flag <= 1'b1;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= load;
      if (load) begin
        bus.alu_out <= res;
        bus.zero_flag <= res == '0;
      end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit covering reset, single-cycle bursts, MUL latency/edges, busy-time requests and mid-multiply reset
module tb_alu_exec_unit;
  import alu_pkg::*;
  localparam int W = DATA_W_DEF;
  typedef struct {
    logic [W-1:0] res;
    logic z;
  } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  alu_exec_unit_if #(.DATA_W(W)) bus ();
  alu_exec_unit #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
    bus.valid_in = 1;
    bus.alu_control = op;
    bus.alu_in_0 = a;
    bus.alu_in_1 = b;
    sb.push_back('{r, r == '0});
  endtask
  task automatic idle;
    bus.valid_in = 0;
  endtask
  task automatic test_reset;
    idle;
    bus.alu_control = 0;
    bus.alu_in_0 = 0;
    bus.alu_in_1 = 0;
    rst = 1;
    tick;
    tick;
    rst = 0;
    n_vec++;
    if ({bus.alu_out, bus.zero_flag, bus.valid_out, bus.busy} !== {{W{1'b0}}, 3'b100}) begin
      n_err++;
      $display("FAIL reset: alu_out=%h zero=%b valid_out=%b busy=%b, expected 0/1/0/0", bus.alu_out, bus.zero_flag, bus.valid_out, bus.busy);
    end
  endtask
  task automatic test_single_burst;
    logic [3:0] ops[10] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_AND, OP_OR, OP_SRL, 4'd5, 4'd9, OP_SLT};
    logic [W-1:0] as[10] = '{64'd5, 64'd7, '1, 64'd1, 64'hF0F0, 64'hF000, 64'h8000_0000_0000_0000, 64'd3, 64'd3, 64'd1};
    logic [W-1:0] bs[10] = '{64'd7, 64'd7, 64'd1, 64'd63, 64'h0FF0, 64'h000F, 64'd63, 64'd4, 64'd4, '1};
    logic [W-1:0] es[10] = '{64'd12, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 64'h00F0, 64'hF00F, 64'd1, 64'd0, 64'd0, 64'd0};
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], as[i], bs[i], es[i]);
      tick;
      e = sb.pop_front();
      n_vec++;
      if (bus.valid_out !== 1 || bus.alu_out !== e.res || bus.zero_flag !== e.z) begin
        n_err++;
        $display("FAIL burst[%0d]: valid_out=%b alu_out=%h zero=%b, expected 1 %h %b", i, bus.valid_out, bus.alu_out, bus.zero_flag, e.res, e.z);
      end
    end
    drive(OP_ADD, 64'd40, 64'd2, 64'd42);
    tick;
    e = sb.pop_front();
    idle;
    bus.alu_in_0 = 64'd99;
    tick;
    n_vec++;
    if (bus.valid_out !== 0 || bus.alu_out !== e.res || bus.zero_flag !== e.z) begin
      n_err++;
      $display("FAIL idle_hold: valid_out=%b alu_out=%h zero=%b, expected 0 %h %b", bus.valid_out, bus.alu_out, bus.zero_flag, e.res, e.z);
    end
  endtask
  task automatic test_random_ops;
    logic [3:0] op;
    logic [W-1:0] a, b, r;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = i[1:0] == 0 ? OP_ADD : i[1:0] == 1 ? OP_SUB : i[1:0] == 2 ? OP_AND : OP_OR;
      r = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : a | b;
      drive(op, a, b, r);
      tick;
      e = sb.pop_front();
      n_vec++;
      if (bus.valid_out !== 1 || bus.alu_out !== e.res || bus.zero_flag !== e.z) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d: valid_out=%b alu_out=%h, expected 1 %h", i, op, bus.valid_out, bus.alu_out, e.res);
      end
    end
    idle;
    tick;
  endtask
  task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit follow, input bit poke);
    exp_t e;
    int cnt;
    logic [W-1:0] p;
    cnt = 0;
    p = a * b;
    drive(OP_MUL, a, b, p);
    tick;
    idle;
    while (bus.busy === 1 && cnt < 200) begin
      n_vec++;
      if (bus.valid_out !== 0) begin
        n_err++;
        $display("FAIL valid_during_busy: cycle %0d valid_out=%b, expected 0", cnt, bus.valid_out);
      end
      if (poke && cnt == 10) begin
        bus.valid_in = 1;
        bus.alu_control = OP_ADD;
        bus.alu_in_0 = 64'd1;
        bus.alu_in_1 = 64'd1;
      end else idle;
      cnt++;
      tick;
    end
    n_vec++;
    if (cnt !== W) begin
      n_err++;
      $display("FAIL mul_busy_cycles: got %0d, expected %0d", cnt, W);
    end
    e = sb.pop_front();
    n_vec++;
    if (bus.valid_out !== 1 || bus.busy !== 0 || bus.alu_out !== e.res || bus.zero_flag !== e.z) begin
      n_err++;
      $display("FAIL mul %h*%h: valid_out=%b busy=%b alu_out=%h zero=%b, expected 1 0 %h %b", a, b, bus.valid_out, bus.busy, bus.alu_out, bus.zero_flag, e.res, e.z);
    end
    if (follow) begin
      drive(OP_ADD, 64'd2, 64'd3, 64'd5);
      tick;
      e = sb.pop_front();
      n_vec++;
      if (bus.valid_out !== 1 || bus.alu_out !== e.res) begin
        n_err++;
        $display("FAIL add_after_mul: valid_out=%b alu_out=%h, expected 1 %h", bus.valid_out, bus.alu_out, e.res);
      end
    end
    idle;
    tick;
    n_vec++;
    if (bus.valid_out !== 0) begin
      n_err++;
      $display("FAIL mul_pulse_width: valid_out=%b, expected 0", bus.valid_out);
    end
  endtask
  task automatic test_reset_mid_mul;
    int seen;
    seen = 0;
    drive(OP_MUL, 64'd100, 64'd100, 64'd10000);
    tick;
    idle;
    repeat (30) tick;
    rst = 1;
    tick;
    rst = 0;
    sb.delete();
    n_vec++;
    if ({bus.alu_out, bus.zero_flag, bus.valid_out, bus.busy} !== {{W{1'b0}}, 3'b100}) begin
      n_err++;
      $display("FAIL reset_mid_mul: alu_out=%h zero=%b valid_out=%b busy=%b, expected 0/1/0/0", bus.alu_out, bus.zero_flag, bus.valid_out, bus.busy);
    end
    repeat (80) begin
      seen += (bus.valid_out === 1 || bus.busy === 1) ? 1 : 0;
      tick;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL discarded_mul: %0d cycles with valid_out/busy, expected 0", seen);
    end
  endtask
  initial begin
    test_reset;
    test_single_burst;
    test_random_ops;
    test_mul(64'd6, 64'd7, 1, 0);
    test_mul('1, 64'd2, 0, 0);
    test_mul(64'd0, 64'd123, 0, 0);
    test_mul(64'd5, 64'd9, 0, 1);
    test_mul(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 0);
    test_mul(-64'sd3, 64'd5, 0, 0);
    test_reset_mid_mul;
    test_mul(64'd3, 64'd3, 0, 0);
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
